uart_tx_frame: RTL



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_bit_timer.sv | 43 ++++
 rtl/uart_tx_frame.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, legal oversampling ratios and parity codes.
// Used by both the TX and RX paths so that prescale handling stays identical on each side.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [5:0] PRESCALE_8       = 6'd8;
  localparam logic [5:0] PRESCALE_16      = 6'd16;
  localparam logic [5:0] PRESCALE_32      = 6'd32;
  localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Any ratio other than 8/16/32 falls back to the default.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
      default:                              return PRESCALE_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: latches the effective prescale at frame acceptance and counts cycles within a bit.
// o_bit_done is high on the last cycle of every bit period while the frame is running.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESCALE = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_run,
  input  logic [5:0] i_prescale,
  output logic       o_bit_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [5:0] DEF_PM1 = PRESCALE_DEFAULT - 6'd1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_pm1;
  logic [5:0]    w_p_legal;
  logic [5:0]    w_pm1_full;
  logic          w_bit_done;

  assign w_p_legal  = legal_prescale(i_prescale);
  assign w_pm1_full = w_p_legal - 6'd1;
  assign w_bit_done = i_run && (r_cnt == r_pm1);
  assign o_bit_done = w_bit_done;

  // Storing P-1 keeps the terminal count within the counter width even for P=32.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_pm1 <= DEF_PM1[CW-1:0];
    end else if (i_load) begin
      r_cnt <= '0;
      r_pm1 <= w_pm1_full[CW-1:0];
    end else if (i_run) begin
      r_cnt <= w_bit_done ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit lasts P oversampling cycles; requests arriving while busy are dropped, not queued.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int PRESCALE   = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [5:0]            i_prescale,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_e           r_state;
  uart_state_e           w_state_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [BW-1:0]         r_bit_cnt;
  logic [BW-1:0]         w_bit_cnt_next;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_busy;
  logic                  w_tx_next;
  logic                  w_accept;
  logic                  w_par_bit;
  logic                  w_run;
  logic                  w_bit_done;

  assign w_accept  = (r_state == ST_IDLE) && i_data_valid;
  assign w_par_bit = (i_par_typ == PAR_ODD) ? ~(^i_data) : (^i_data);
  assign w_run     = (r_state != ST_IDLE);

  uart_tx_bit_timer #(
    .PRESCALE (PRESCALE)
  ) u_bit_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_accept),
    .i_run      (w_run),
    .i_prescale (i_prescale),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_tx_next      = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (i_data_valid) begin
          w_state_next = ST_START;
          w_shift_next = i_data;
        end
      end
      ST_START: begin
        if (w_bit_done) begin
          w_state_next   = ST_DATA;
          w_bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_done) begin
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Line level is decided from the next state so the pin itself is a flop.
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = r_par_bit;
      default:   w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != ST_IDLE);
      if (w_accept) begin
        r_par_en  <= i_par_en;
        r_par_bit <= w_par_bit;
      end
    end
  end

  assign o_tx_out = r_tx;
  assign o_busy   = r_busy;

endmodule
